// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select encodings, nop word, reset vector.
package fetch_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC select, redirect alignment and sticky misalignment flag.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] pc_branch,
  input  logic [WIDTH-1:0] pc_jump,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus4_c,
  output logic             misalign_err
);

  logic             redirect_c;
  logic [WIDTH-1:0] target_c;
  logic [WIDTH-1:0] next_pc_c;

  // Sequential increment wraps naturally; redirect targets are forced word-aligned.
  always_comb begin
    pc_plus4_c = pc_f + WIDTH'(4);
    redirect_c = 1'b0;
    target_c   = pc_plus4_c;
    case (pc_src)
      PCSRC_BRANCH: begin
        redirect_c = 1'b1;
        target_c   = pc_branch;
      end
      PCSRC_JUMP: begin
        redirect_c = 1'b1;
        target_c   = pc_jump;
      end
      default: begin
        redirect_c = 1'b0;
        target_c   = pc_plus4_c;
      end
    endcase
    next_pc_c = redirect_c ? {target_c[WIDTH-1:2], 2'b00} : pc_plus4_c;
  end

  // PC update; a stall holds the PC and drops any redirect presented that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else if (!stall_f) begin
      pc_f <= next_pc_c;
    end
  end

  // Sticky error: set only when a redirect is actually taken to an unaligned target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (!stall_f && redirect_c && (target_c[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] PC_F,
  input  logic [WIDTH-1:0] RD_F,
  input  logic             STALL_F,
  input  logic             STALL_D,
  input  logic             FLUSH_D,
  input  logic [1:0]       PC_SRC,
  input  logic [WIDTH-1:0] PC_BRANCH,
  input  logic [WIDTH-1:0] PC_JUMP,
  output logic [WIDTH-1:0] INSTR_D,
  output logic [WIDTH-1:0] PC_PLUS4_D,
  output logic             VALID_D,
  output logic             MISALIGN_ERR
);

  logic [WIDTH-1:0] pc_plus4_f;

  pc_register #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk          (CLK),
    .rst          (RST),
    .stall_f      (STALL_F),
    .pc_src       (PC_SRC),
    .pc_branch    (PC_BRANCH),
    .pc_jump      (PC_JUMP),
    .pc_f         (PC_F),
    .pc_plus4_c   (pc_plus4_f),
    .misalign_err (MISALIGN_ERR)
  );

  // IF/ID register: flush inserts a bubble and wins over stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INSTR_D    <= WIDTH'(NOP_INSTR);
      PC_PLUS4_D <= '0;
      VALID_D    <= 1'b0;
    end else if (FLUSH_D) begin
      INSTR_D    <= WIDTH'(NOP_INSTR);
      PC_PLUS4_D <= '0;
      VALID_D    <= 1'b0;
    end else if (!STALL_D) begin
      INSTR_D    <= RD_F;
      PC_PLUS4_D <= pc_plus4_f;
      VALID_D    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: spec-level model plus pinned literal checks.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] PC_F, RD_F, INSTR_D, PC_PLUS4_D;
  logic        VALID_D, MISALIGN_ERR;
  logic        STALL_F = 1'b0, STALL_D = 1'b0, FLUSH_D = 1'b0;
  logic [1:0]  PC_SRC = 2'b00;
  logic [31:0] PC_BRANCH = '0, PC_JUMP = '0;

  // second instance with the reset vector at the top of the address space
  logic        rst_w = 1'b0;
  logic [31:0] pc_w, rd_w, instr_w, pp4_w;
  logic        valid_w, err_w;
  logic        zero_w = 1'b0;
  logic [1:0]  src_w = 2'b00;
  logic [31:0] tgt_w = '0;

  logic [31:0] rom [0:255];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | 32'(i);
  end

  assign RD_F = rom[PC_F[9:2]];
  assign rd_w = rom[pc_w[9:2]];

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .PC_F(PC_F), .RD_F(RD_F),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .FLUSH_D(FLUSH_D),
    .PC_SRC(PC_SRC), .PC_BRANCH(PC_BRANCH), .PC_JUMP(PC_JUMP),
    .INSTR_D(INSTR_D), .PC_PLUS4_D(PC_PLUS4_D), .VALID_D(VALID_D),
    .MISALIGN_ERR(MISALIGN_ERR)
  );

  fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .RST(rst_w), .PC_F(pc_w), .RD_F(rd_w),
    .STALL_F(zero_w), .STALL_D(zero_w), .FLUSH_D(zero_w),
    .PC_SRC(src_w), .PC_BRANCH(tgt_w), .PC_JUMP(tgt_w),
    .INSTR_D(instr_w), .PC_PLUS4_D(pp4_w), .VALID_D(valid_w),
    .MISALIGN_ERR(err_w)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must hold after each edge.
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pp4 = 32'h0;
  logic        m_valid = 1'b0, m_err = 1'b0;

  always @(posedge CLK or posedge RST) begin : model
    logic [31:0] seq, tgt;
    if (RST) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_pp4 <= 32'h0; m_valid <= 1'b0; m_err <= 1'b0;
    end else begin
      seq = m_pc + 32'd4;
      if (FLUSH_D) begin
        m_instr <= 32'h0; m_pp4 <= 32'h0; m_valid <= 1'b0;
      end else if (!STALL_D) begin
        m_instr <= rom[m_pc[9:2]]; m_pp4 <= seq; m_valid <= 1'b1;
      end
      if (!STALL_F) begin
        if (PC_SRC == 2'b01 || PC_SRC == 2'b10) begin
          tgt = (PC_SRC == 2'b01) ? PC_BRANCH : PC_JUMP;
          m_pc <= tgt & 32'hFFFF_FFFC;
          if (tgt % 4 != 0) m_err <= 1'b1;
        end else begin
          m_pc <= seq;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("m_pc_f", PC_F, m_pc);
    chk("m_instr_d", INSTR_D, m_instr);
    chk("m_pc_plus4_d", PC_PLUS4_D, m_pp4);
    chk("m_valid_d", 32'(VALID_D), 32'(m_valid));
    chk("m_misalign_err", 32'(MISALIGN_ERR), 32'(m_err));
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    #1 RST = 1'b1; rst_w = 1'b1;
    tick();
    chk("rst_pc_f", PC_F, 32'h0);
    chk("rst_instr_d", INSTR_D, 32'h0);
    chk("rst_valid_d", 32'(VALID_D), 32'h0);
    chk("rst_w_pc_f", pc_w, 32'hFFFF_FFFC);
    RST = 1'b0; rst_w = 1'b0;

    tick();
    chk("seq_pc_4", PC_F, 32'h4);
    chk("seq_instr_0", INSTR_D, 32'hA500_0000);
    chk("seq_valid", 32'(VALID_D), 32'h1);
    chk("wrap_pc_f", pc_w, 32'h0);
    chk("wrap_pp4_d", pp4_w, 32'h0);
    chk("wrap_instr_d", instr_w, 32'hA500_00FF);
    tick();
    chk("seq_pc_8", PC_F, 32'h8);
    chk("seq_instr_1", INSTR_D, 32'hA500_0001);
    tick();
    chk("seq_pc_c", PC_F, 32'hC);
    chk("seq_instr_2", INSTR_D, 32'hA500_0002);
    PC_SRC = 2'b10; PC_JUMP = 32'h8;
    tick();
    chk("jump_back_pc", PC_F, 32'h8);
    PC_SRC = 2'b01; PC_BRANCH = 32'h40; FLUSH_D = 1'b1;
    tick();
    chk("br_pc", PC_F, 32'h40);
    chk("br_bubble_instr", INSTR_D, 32'h0);
    chk("br_bubble_valid", 32'(VALID_D), 32'h0);
    PC_SRC = 2'b00; FLUSH_D = 1'b0;
    tick();
    chk("br_instr", INSTR_D, 32'hA500_0010);
    chk("br_pc_next", PC_F, 32'h44);
    PC_SRC = 2'b10; PC_JUMP = 32'h10;
    tick();
    chk("pre_stall_pc", PC_F, 32'h10);
    PC_SRC = 2'b00; STALL_F = 1'b1; STALL_D = 1'b1;
    tick();
    tick();
    chk("stall_pc", PC_F, 32'h10);
    chk("stall_instr", INSTR_D, 32'hA500_0011);
    chk("stall_pp4", PC_PLUS4_D, 32'h48);
    STALL_F = 1'b0; STALL_D = 1'b0;
    tick();
    chk("resume_pc", PC_F, 32'h14);
    chk("resume_instr", INSTR_D, 32'hA500_0004);
    STALL_F = 1'b1;
    tick();
    tick();
    chk("recap_pc", PC_F, 32'h14);
    chk("recap_instr", INSTR_D, 32'hA500_0005);
    STALL_F = 1'b0;
    tick();
    STALL_D = 1'b1; FLUSH_D = 1'b1;
    tick();
    chk("flush_over_stall_valid", 32'(VALID_D), 32'h0);
    chk("flush_over_stall_instr", INSTR_D, 32'h0);
    STALL_D = 1'b0; FLUSH_D = 1'b0;
    tick();
    STALL_F = 1'b1; PC_SRC = 2'b01; PC_BRANCH = 32'h81;
    tick();
    chk("lost_redirect_pc", PC_F, 32'h20);
    chk("lost_redirect_err", 32'(MISALIGN_ERR), 32'h0);
    STALL_F = 1'b0; PC_BRANCH = 32'h80;
    tick();
    chk("kept_redirect_pc", PC_F, 32'h80);
    PC_SRC = 2'b10; PC_JUMP = 32'h103;
    tick();
    chk("misalign_pc", PC_F, 32'h100);
    chk("misalign_err", 32'(MISALIGN_ERR), 32'h1);
    PC_SRC = 2'b00;
    repeat (5) tick();
    chk("misalign_sticky", 32'(MISALIGN_ERR), 32'h1);
    chk("post_misalign_pc", PC_F, 32'h114);
    PC_SRC = 2'b11;
    tick();
    chk("rsvd_seq_pc", PC_F, 32'h118);
    STALL_F = 1'b1; PC_SRC = 2'b01; PC_BRANCH = 32'h200;
    #2 RST = 1'b1; rst_w = 1'b1;
    #1;
    chk("async_rst_pc", PC_F, 32'h0);
    chk("async_rst_instr", INSTR_D, 32'h0);
    chk("async_rst_pp4", PC_PLUS4_D, 32'h0);
    chk("async_rst_valid", 32'(VALID_D), 32'h0);
    chk("async_rst_err", 32'(MISALIGN_ERR), 32'h0);
    chk("async_rst_w_pc", pc_w, 32'hFFFF_FFFC);
    chk("async_rst_w_valid", 32'(valid_w), 32'h0);
    tick();
    RST = 1'b0; rst_w = 1'b0; STALL_F = 1'b0; PC_SRC = 2'b00;
    tick();
    chk("post_rst_pc", PC_F, 32'h4);
    chk("post_rst_instr", INSTR_D, 32'hA500_0000);
    chk("post_rst_w_pc", pc_w, 32'h0);
    tick();
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, which is the data and address width.
REQ-002 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, which is the first fetch address and SHALL be word-aligned.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port PC_F, output, WIDTH bits: the fetch address, driven to the instruction memory address input.
REQ-006 The block SHALL have port RD_F, input, WIDTH bits: the instruction word returned combinationally by the instruction memory for PC_F.
REQ-007 The block SHALL have port STALL_F, input, 1 bit: when high, PC_F holds its value.
REQ-008 The block SHALL have port STALL_D, input, 1 bit: when high, the IF/ID register holds its value.
REQ-009 The block SHALL have port FLUSH_D, input, 1 bit: when high, a bubble is loaded into the IF/ID register.
REQ-010 The block SHALL have port PC_SRC, input, 2 bits, with encodings 00 = sequential, 01 = branch, 10 = jump, 11 = reserved.
REQ-011 The block SHALL have port PC_BRANCH, input, WIDTH bits: the branch target address.
REQ-012 The block SHALL have port PC_JUMP, input, WIDTH bits: the jump target address.
REQ-013 The block SHALL have port INSTR_D, output, WIDTH bits: the registered instruction presented to decode.
REQ-014 The block SHALL have port PC_PLUS4_D, output, WIDTH bits: the registered PC_F+4 of that instruction.
REQ-015 The block SHALL have port VALID_D, output, 1 bit: high when INSTR_D is a real fetched instruction.
REQ-016 The block SHALL have port MISALIGN_ERR, output, 1 bit: a sticky flag set when a redirect target is not word-aligned.

Function
REQ-017 The block SHALL compute PC_PLUS4_F = PC_F + 4 modulo 2^WIDTH, so that 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-018 The block SHALL select the next PC as: sequential -> PC_PLUS4_F; branch -> PC_BRANCH; jump -> PC_JUMP; reserved -> PC_PLUS4_F.
REQ-019 For a redirect, the block SHALL force bits [1:0] of the selected target to 00 before loading it into PC_F.
REQ-020 If a redirect is taken with target[1:0] != 00, the block SHALL set MISALIGN_ERR on that edge; the flag SHALL clear only on reset.
REQ-021 When STALL_F is high, the block SHALL hold PC_F regardless of PC_SRC, so a redirect is lost; the hazard unit SHALL keep PC_SRC asserted until STALL_F is low.
REQ-022 On each edge where FLUSH_D is low and STALL_D is low, the block SHALL load INSTR_D <= RD_F, PC_PLUS4_D <= PC_PLUS4_F, and VALID_D <= 1.
REQ-023 When STALL_D is high and FLUSH_D is low, the block SHALL hold INSTR_D, PC_PLUS4_D and VALID_D.
REQ-024 When FLUSH_D is high, the block SHALL load INSTR_D <= 32'h0000_0000 (nop), PC_PLUS4_D <= 0 and VALID_D <= 0; FLUSH_D SHALL override STALL_D.
REQ-025 Fetch-to-decode latency SHALL be exactly one cycle: the instruction at PC_F in cycle n SHALL appear on INSTR_D in cycle n+1.
REQ-026 The PC path and the IF/ID path SHALL stall independently; STALL_F=1 with STALL_D=0 re-captures the same instruction.

Reset
REQ-027 While RST is high, the block SHALL asynchronously force PC_F=RESET_PC, INSTR_D=0, PC_PLUS4_D=0, VALID_D=0 and MISALIGN_ERR=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first edge after deassertion SHALL fetch RESET_PC into the IF/ID register.

Structure
REQ-029 A shared package SHALL hold the PC_SRC encodings (PCSRC_SEQ, PCSRC_BRANCH, PCSRC_JUMP), the constant NOP_INSTR=32'h0, and the default RESET_PC.
REQ-030 The PC register with its next-PC mux SHALL be a sub-module named pc_register; the IF/ID register SHALL be in fetch_stage.

Verification
REQ-031 The bench SHALL cover reset release followed by 3 cycles of PC_SRC=00 -> PC_F=0,4,8,12 and INSTR_D lagging one cycle with VALID_D=1.
REQ-032 The bench SHALL cover PC_SRC=01 with PC_BRANCH=0x40 at PC_F=0x8, with FLUSH_D=1 -> next PC_F=0x40, INSTR_D=0 and VALID_D=0, then INSTR_D=ROM[0x40>>2].
REQ-033 The bench SHALL cover STALL_F=STALL_D=1 for 2 cycles at PC_F=0x10 -> PC_F, INSTR_D and PC_PLUS4_D unchanged, resuming at 0x14.
REQ-034 The bench SHALL cover STALL_D=1 with FLUSH_D=1 -> bubble loaded (VALID_D=0).
REQ-035 The bench SHALL cover PC_SRC=10 with PC_JUMP=0x103 -> PC_F=0x100 and MISALIGN_ERR=1, still set after 5 more cycles.
REQ-036 The bench SHALL cover RESET_PC=0xFFFF_FFFC -> the next PC_F is 0x0000_0000; then RST asserted mid-cycle -> outputs reset immediately, without waiting for a clock edge.
